// File: rtl/if_fetch.sv
// Instruction-fetch stage: assembles 32-bit little-endian words from a byte-wide memory port.
// Define ICACHE_EN to add a direct-mapped, one-word-per-line instruction cache.
module if_fetch #(
    parameter logic [31:0] RESET_PC       = 32'h0,
    parameter int          ICACHE_INDEX_W = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ifid_stall,
    input  logic        branch_interception,
    input  logic [31:0] branch_target,
    input  logic        mem_byte_valid,
    input  logic [7:0]  mem_byte,
    output logic        if_mem_req,
    output logic [31:0] if_mem_addr,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst
);

    // state  | meaning
    // S_IDLE | single cycle after reset
    // S_FETCH| requesting bytes of the word at pc (or hitting in the cache)
    // S_HOLD | an instruction was emitted into a stalled IF/ID; wait for stall release
    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HOLD} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [23:0] word_q, word_d;
    logic        abort_q;
    logic        hit;
    logic [31:0] hit_word;
    logic        byte_take;
    logic        mem_done;
    logic        done;
    logic        emit;
    logic [31:0] done_word;

    // abort_q holds the request low for the cycle after a redirect
    assign if_mem_req  = (state_q == S_FETCH) && !abort_q && !hit;
    assign if_mem_addr = if_mem_req ? (pc_q + {30'b0, byte_cnt_q}) : 32'h0;
    assign byte_take   = if_mem_req && mem_byte_valid;
    assign mem_done    = byte_take && (byte_cnt_q == 2'd3);
    assign done        = hit || mem_done;
    assign emit        = done && !branch_interception;
    assign done_word   = hit ? hit_word : {mem_byte, word_q};

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        byte_cnt_d = byte_cnt_q;
        word_d     = word_q;
        unique case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                if (done) begin
                    pc_d       = pc_q + 32'd4;
                    byte_cnt_d = 2'd0;
                    state_d    = ifid_stall ? S_HOLD : S_FETCH;
                end else if (byte_take) begin
                    case (byte_cnt_q)
                        2'd0:    word_d[7:0]   = mem_byte;
                        2'd1:    word_d[15:8]  = mem_byte;
                        2'd2:    word_d[23:16] = mem_byte;
                        default: word_d        = word_q;
                    endcase
                    byte_cnt_d = byte_cnt_q + 2'd1;
                end
            end
            S_HOLD: if (!ifid_stall) state_d = S_FETCH;
            default: state_d = S_IDLE;
        endcase
        if (branch_interception) begin
            pc_d       = branch_target;
            byte_cnt_d = 2'd0;
            word_d     = 24'h0;
            state_d    = S_FETCH;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            byte_cnt_q <= 2'd0;
            word_q     <= 24'h0;
            abort_q    <= 1'b0;
            if_inst    <= 32'h0;
            if_pc      <= 32'h0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            byte_cnt_q <= byte_cnt_d;
            word_q     <= word_d;
            abort_q    <= branch_interception;
            if_inst    <= emit ? done_word : 32'h0;
            if_pc      <= emit ? pc_q : 32'h0;
        end
    end

`ifdef ICACHE_EN
    localparam int LINES = 1 << ICACHE_INDEX_W;
    localparam int TAG_W = 30 - ICACHE_INDEX_W;

    logic [31:0]               c_data [LINES];
    logic [TAG_W-1:0]          c_tag  [LINES];
    logic [LINES-1:0]          c_valid;
    logic [ICACHE_INDEX_W-1:0] idx;
    logic [TAG_W-1:0]          tag;
    logic                      fill;

    assign idx      = pc_q[ICACHE_INDEX_W+1:2];
    assign tag      = pc_q[31:ICACHE_INDEX_W+2];
    assign hit      = (state_q == S_FETCH) && (byte_cnt_q == 2'd0) && c_valid[idx] && (c_tag[idx] == tag);
    assign hit_word = c_data[idx];
    // a fill aborted by a redirect on the same edge leaves the line untouched
    assign fill     = mem_done && !branch_interception;

    always_ff @(posedge clk) begin
        if (!rst) begin
            c_valid <= '0;
        end else if (fill) begin
            c_valid[idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (fill) begin
            c_data[idx] <= done_word;
            c_tag[idx]  <= tag;
        end
    end
`else
    assign hit      = 1'b0;
    assign hit_word = 32'h0;
`endif

endmodule
